// File: rtl/axi_slave_mem_responder.sv
// AXI4 slave responder backed by an internal word-addressed memory.
// Independent write (AW/W/B) and read (AR/R) FSMs, one outstanding
// transaction each, INCR bursts up to 256 beats at full data width.
// Optional macro AXI_SLV_RD_DELAY_EN inserts RD_DELAY wait cycles
// between the AR handshake and the first R beat.
module axi_slave_mem_responder #(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH    = 256,
  parameter int AXI4_ID_WIDTH      = 18,
  parameter int MEM_DEPTH          = 1024,
  parameter int RD_DELAY           = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETn,
  input  logic [AXI4_ID_WIDTH-1:0]        AWID,
  input  logic [AXI4_ADDRESS_WIDTH-1:0]   AWADDR,
  input  logic [7:0]                      AWLEN,
  input  logic                            AWVALID,
  output logic                            AWREADY,
  input  logic [AXI4_DATA_WIDTH-1:0]      WDATA,
  input  logic [AXI4_DATA_WIDTH/8-1:0]    WSTRB,
  input  logic                            WLAST,
  input  logic                            WVALID,
  output logic                            WREADY,
  output logic [AXI4_ID_WIDTH-1:0]        BID,
  output logic [1:0]                      BRESP,
  output logic                            BVALID,
  input  logic                            BREADY,
  input  logic [AXI4_ID_WIDTH-1:0]        ARID,
  input  logic [AXI4_ADDRESS_WIDTH-1:0]   ARADDR,
  input  logic [7:0]                      ARLEN,
  input  logic                            ARVALID,
  output logic                            ARREADY,
  output logic [AXI4_ID_WIDTH-1:0]        RID,
  output logic [AXI4_DATA_WIDTH-1:0]      RDATA,
  output logic [1:0]                      RRESP,
  output logic                            RLAST,
  output logic                            RVALID,
  input  logic                            RREADY
);

  localparam int unsigned NB    = AXI4_DATA_WIDTH / 8;
  localparam int          SHIFT = $clog2(AXI4_DATA_WIDTH / 8);
  localparam int          MW    = $clog2(MEM_DEPTH);
  localparam int          AW    = AXI4_ADDRESS_WIDTH;
  localparam logic [AW-1:0] DEPTH = AW'(MEM_DEPTH);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_DATA = 2'd1;
`ifdef AXI_SLV_RD_DELAY_EN
  localparam logic [1:0] R_WAIT = 2'd2;
  logic [15:0] r_dly;
`else
  localparam int unused_rd_delay = RD_DELAY;
`endif

  logic [AXI4_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [1:0]    w_state;
  logic [AW-1:0] w_idx;
  logic [7:0]    w_cnt;
  logic          w_err;
  logic          w_in_range;
  logic          w_bad;

  logic [1:0]                 r_state;
  logic [AW-1:0]              r_idx;
  logic [7:0]                 r_cnt;
  logic [AW-1:0]              r_ld_idx;
  logic                       r_ld_ok;
  logic [AXI4_DATA_WIDTH-1:0] r_ld_data;
  logic [1:0]                 r_ld_resp;

  // Per-beat write error: out-of-range index or WLAST disagreeing with the beat count
  always_comb begin
    w_in_range = (w_idx < DEPTH);
    w_bad      = !w_in_range || (WLAST != (w_cnt == 8'd0));
  end

  // Write FSM: accept AW, count W beats, hold B until accepted
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state <= W_IDLE;
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BRESP   <= '0;
      BID     <= '0;
      w_idx   <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (AWVALID && AWREADY) begin
            BID     <= AWID;
            w_idx   <= AWADDR >> SHIFT;
            w_cnt   <= AWLEN;
            w_err   <= 1'b0;
            AWREADY <= 1'b0;
            WREADY  <= 1'b1;
            w_state <= W_DATA;
          end else begin
            AWREADY <= 1'b1;
          end
        end
        W_DATA: begin
          if (WVALID && WREADY) begin
            w_idx <= w_idx + AW'(1);
            w_cnt <= w_cnt - 8'd1;
            w_err <= w_err | w_bad;
            if (w_cnt == 8'd0) begin
              WREADY  <= 1'b0;
              BVALID  <= 1'b1;
              BRESP   <= (w_err || w_bad) ? 2'b10 : 2'b00;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            BRESP   <= '0;
            AWREADY <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Byte-enabled memory write for in-range beats; contents survive reset
  always_ff @(posedge ACLK) begin
    if (w_state == W_DATA && WVALID && WREADY && w_in_range) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (WSTRB[b]) mem[w_idx[MW-1:0]][b*8 +: 8] <= WDATA[b*8 +: 8];
      end
    end
  end

  // Index of the beat to be presented next, and its data/response
  always_comb begin
    case (r_state)
      R_DATA:  r_ld_idx = r_idx + AW'(1);
`ifdef AXI_SLV_RD_DELAY_EN
      R_WAIT:  r_ld_idx = r_idx;
`endif
      default: r_ld_idx = ARADDR >> SHIFT;
    endcase
    r_ld_ok   = (r_ld_idx < DEPTH);
    r_ld_data = r_ld_ok ? mem[r_ld_idx[MW-1:0]] : '0;
    r_ld_resp = r_ld_ok ? 2'b00 : 2'b10;
  end

  // Read FSM: accept AR, optionally wait, then present registered beats
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RLAST   <= 1'b0;
      RRESP   <= '0;
      RID     <= '0;
      RDATA   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
`ifdef AXI_SLV_RD_DELAY_EN
      r_dly   <= '0;
`endif
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ARVALID && ARREADY) begin
            ARREADY <= 1'b0;
            RID     <= ARID;
            r_idx   <= r_ld_idx;
            r_cnt   <= ARLEN;
`ifdef AXI_SLV_RD_DELAY_EN
            if (RD_DELAY != 0) begin
              r_dly   <= 16'(RD_DELAY);
              r_state <= R_WAIT;
            end else begin
              RVALID  <= 1'b1;
              RDATA   <= r_ld_data;
              RRESP   <= r_ld_resp;
              RLAST   <= (ARLEN == 8'd0);
              r_state <= R_DATA;
            end
`else
            RVALID  <= 1'b1;
            RDATA   <= r_ld_data;
            RRESP   <= r_ld_resp;
            RLAST   <= (ARLEN == 8'd0);
            r_state <= R_DATA;
`endif
          end else begin
            ARREADY <= 1'b1;
          end
        end
`ifdef AXI_SLV_RD_DELAY_EN
        R_WAIT: begin
          // First beat is loaded on the edge where the counter reaches zero
          r_dly <= r_dly - 16'd1;
          if (r_dly == 16'd1) begin
            RVALID  <= 1'b1;
            RDATA   <= r_ld_data;
            RRESP   <= r_ld_resp;
            RLAST   <= (r_cnt == 8'd0);
            r_state <= R_DATA;
          end
        end
`endif
        R_DATA: begin
          if (RREADY) begin
            if (RLAST) begin
              RVALID  <= 1'b0;
              RLAST   <= 1'b0;
              RRESP   <= '0;
              RDATA   <= '0;
              ARREADY <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_idx <= r_ld_idx;
              r_cnt <= r_cnt - 8'd1;
              RDATA <= r_ld_data;
              RRESP <= r_ld_resp;
              RLAST <= (r_cnt == 8'd1);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_mem_responder.sv
// Self-checking bench for axi_slave_mem_responder: directed scenarios plus
// randomized bursts, checked against an array-based reference memory.
module tb_axi_slave_mem_responder;

  localparam int AW = 32, DW = 256, IW = 18, DEPTH = 1024, RDLY = 4, NB = DW / 8;

  logic ACLK = 1'b0, ARESETn = 1'b0;
  logic [IW-1:0] AWID, BID, ARID, RID;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [7:0]    AWLEN, ARLEN;
  logic          AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [DW-1:0] WDATA, RDATA;
  logic [NB-1:0] WSTRB;
  logic [1:0]    BRESP, RRESP;

  always #5 ACLK = ~ACLK;

  axi_slave_mem_responder #(
    .AXI4_ADDRESS_WIDTH(AW), .AXI4_DATA_WIDTH(DW), .AXI4_ID_WIDTH(IW),
    .MEM_DEPTH(DEPTH), .RD_DELAY(RDLY)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] wq [$];
  logic [NB-1:0] sq [$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic do_write(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                          input int b_stall, input bit bad_last, input bit chk_lat);
    int t;
    int unsigned idx;
    bit err;
    logic [1:0] eresp;
    AWID = id; AWADDR = addr; AWLEN = 8'(len); AWVALID = 1'b1;
    t = 0;
    while (AWREADY !== 1'b1 && t < 64) begin @(posedge ACLK); #1; t++; end
    n_checks++;
    if (AWREADY !== 1'b1) begin n_fail++; $display("FAIL aw_timeout: AWREADY=%b required 1", AWREADY); end
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    idx = int'(addr >> 5);
    err = bad_last;
    for (int i = 0; i <= len; i++) begin
      WDATA = wq[i]; WSTRB = sq[i]; WLAST = (i == len) && !bad_last; WVALID = 1'b1;
      if (chk_lat && i == 0) begin
        n_checks++;
        if (WREADY !== 1'b1) begin n_fail++; $display("FAIL w_first_latency: WREADY=%b required 1", WREADY); end
      end
      t = 0;
      while (WREADY !== 1'b1 && t < 64) begin @(posedge ACLK); #1; t++; end
      n_checks++;
      if (WREADY !== 1'b1) begin n_fail++; $display("FAIL w_timeout: WREADY=%b required 1", WREADY); end
      @(posedge ACLK); #1;
      if (idx < DEPTH) begin
        for (int b = 0; b < NB; b++) if (sq[i][b]) ref_mem[idx][b*8 +: 8] = wq[i][b*8 +: 8];
      end else err = 1'b1;
      idx++;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    eresp = err ? 2'b10 : 2'b00;
    if (chk_lat) begin
      n_checks++;
      if (BVALID !== 1'b1) begin n_fail++; $display("FAIL b_latency: BVALID=%b required 1", BVALID); end
    end
    t = 0;
    while (BVALID !== 1'b1 && t < 64) begin @(posedge ACLK); #1; t++; end
    n_checks++;
    if (BVALID !== 1'b1) begin n_fail++; $display("FAIL b_timeout: BVALID=%b required 1", BVALID); end
    n_checks++;
    if (BRESP !== eresp) begin n_fail++; $display("FAIL bresp: got %b required %b", BRESP, eresp); end
    n_checks++;
    if (BID !== id) begin n_fail++; $display("FAIL bid: got %0h required %0h", BID, id); end
    for (int k = 0; k < b_stall; k++) begin
      @(posedge ACLK); #1;
      n_checks++;
      if (BVALID !== 1'b1 || BRESP !== eresp)
        begin n_fail++; $display("FAIL b_stable: BVALID=%b BRESP=%b required 1/%b", BVALID, BRESP, eresp); end
    end
    BREADY = 1'b1;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    n_checks++;
    if (BVALID !== 1'b0 || AWREADY !== 1'b1)
      begin n_fail++; $display("FAIL b2b_aw: BVALID=%b AWREADY=%b required 0/1", BVALID, AWREADY); end
  endtask

  task automatic do_read(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                         input int stall_beat, input int stall_cyc, input bit chk_lat);
    int t;
    int unsigned idx;
    logic [DW-1:0] edata;
    logic [1:0] eresp;
    ARID = id; ARADDR = addr; ARLEN = 8'(len); ARVALID = 1'b1;
    t = 0;
    while (ARREADY !== 1'b1 && t < 64) begin @(posedge ACLK); #1; t++; end
    n_checks++;
    if (ARREADY !== 1'b1) begin n_fail++; $display("FAIL ar_timeout: ARREADY=%b required 1", ARREADY); end
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    if (chk_lat) begin
`ifdef AXI_SLV_RD_DELAY_EN
      for (int k = 0; k < RDLY; k++) begin
        n_checks++;
        if (RVALID !== 1'b0) begin n_fail++; $display("FAIL rd_delay_early: RVALID=%b required 0 at wait %0d", RVALID, k); end
        @(posedge ACLK); #1;
      end
`endif
      n_checks++;
      if (RVALID !== 1'b1) begin n_fail++; $display("FAIL rd_first_latency: RVALID=%b required 1", RVALID); end
    end
    idx = int'(addr >> 5);
    for (int i = 0; i <= len; i++) begin
      edata = (idx < DEPTH) ? ref_mem[idx] : '0;
      eresp = (idx < DEPTH) ? 2'b00 : 2'b10;
      t = 0;
      while (RVALID !== 1'b1 && t < 64) begin @(posedge ACLK); #1; t++; end
      n_checks++;
      if (RVALID !== 1'b1) begin n_fail++; $display("FAIL r_timeout: RVALID=%b required 1 beat %0d", RVALID, i); end
      n_checks++;
      if (RDATA !== edata) begin n_fail++; $display("FAIL rdata beat %0d: got %h required %h", i, RDATA, edata); end
      n_checks++;
      if (RRESP !== eresp || RLAST !== (i == len) || RID !== id)
        begin n_fail++; $display("FAIL rresp_rlast_rid beat %0d: got %b/%b/%0h required %b/%b/%0h", i, RRESP, RLAST, RID, eresp, (i == len), id); end
      if (i == stall_beat) begin
        for (int k = 0; k < stall_cyc; k++) begin
          @(posedge ACLK); #1;
          n_checks++;
          if (RVALID !== 1'b1 || RDATA !== edata || RRESP !== eresp)
            begin n_fail++; $display("FAIL r_stable beat %0d: RVALID=%b RDATA=%h required 1/%h", i, RVALID, RDATA, edata); end
        end
      end
      RREADY = 1'b1;
      @(posedge ACLK); #1;
      RREADY = 1'b0;
      idx++;
    end
    n_checks++;
    if (RVALID !== 1'b0 || ARREADY !== 1'b1)
      begin n_fail++; $display("FAIL b2b_ar: RVALID=%b ARREADY=%b required 0/1", RVALID, ARREADY); end
  endtask

  task automatic fill(input int len, input bit full_strb, input logic [DW-1:0] val, input bit use_val);
    wq.delete(); sq.delete();
    for (int i = 0; i <= len; i++) begin
      wq.push_back(use_val ? val : rand_word());
      sq.push_back(full_strb ? {NB{1'b1}} : NB'($urandom));
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_checks++;
    if ({AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, BRESP, RRESP} !== 10'd0 ||
        BID !== '0 || RID !== '0 || RDATA !== '0)
      begin n_fail++; $display("FAIL %s: ctl=%b BID=%0h RID=%0h RDATA=%h required all 0", tag,
        {AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, BRESP, RRESP}, BID, RID, RDATA); end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge ACLK);
    #1;
    check_all_zero("reset_outputs");
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    n_checks++;
    if (AWREADY !== 1'b1 || ARREADY !== 1'b1)
      begin n_fail++; $display("FAIL ready_after_reset: AWREADY=%b ARREADY=%b required 1/1", AWREADY, ARREADY); end
  endtask

  task automatic test_single();
    fill(0, 1'b1, {32{8'hA5}}, 1'b1);
    do_write(18'h1, 32'h40, 0, 0, 1'b0, 1'b1);
    do_read(18'h2, 32'h40, 0, -1, 0, 1'b1);
  endtask

  task automatic test_burst();
    wq.delete(); sq.delete();
    for (int i = 0; i < 8; i++) begin wq.push_back(DW'(i)); sq.push_back({NB{1'b1}}); end
    do_write(18'h3, 32'h100, 7, 0, 1'b0, 1'b1);
    do_read(18'h5, 32'h100, 7, -1, 0, 1'b1);
  endtask

  task automatic test_strobe();
    fill(0, 1'b1, {DW{1'b1}}, 1'b1);
    do_write(18'h6, 32'h800, 0, 0, 1'b0, 1'b0);
    wq.delete(); sq.delete();
    wq.push_back('0); sq.push_back(NB'(32'h0000_000F));
    do_write(18'h7, 32'h800, 0, 0, 1'b0, 1'b0);
    do_read(18'h8, 32'h800, 0, -1, 0, 1'b0);
  endtask

  task automatic test_out_of_range();
    fill(3, 1'b1, '0, 1'b0);
    do_write(18'h9, AW'((DEPTH - 2) << 5), 3, 0, 1'b0, 1'b0);
    do_read(18'hA, AW'((DEPTH - 2) << 5), 3, -1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    fill(5, 1'b1, '0, 1'b0);
    do_write(18'hB, 32'h1000, 5, 3, 1'b0, 1'b0);
    do_read(18'hC, 32'h1000, 5, 2, 5, 1'b0);
  endtask

  task automatic test_concurrent();
    fill(7, 1'b1, '0, 1'b0);
    fork
      do_write(18'h11, 32'h3000, 7, 1, 1'b0, 1'b0);
      do_read(18'h12, 32'h100, 7, 3, 2, 1'b0);
    join
    do_read(18'h13, 32'h3000, 7, -1, 0, 1'b0);
  endtask

  task automatic test_random();
    int unsigned idx;
    int len;
    logic [AW-1:0] addr;
    for (int it = 0; it < 16; it++) begin
      idx  = ($urandom_range(0, 1) == 1) ? $urandom_range(DEPTH - 12, DEPTH + 2) : $urandom_range(0, DEPTH - 20);
      len  = $urandom_range(0, 15);
      addr = AW'(idx << 5) | AW'($urandom_range(0, 31));
      fill(len, 1'b1, '0, 1'b0);
      do_write(IW'($urandom), addr, len, 0, 1'b0, 1'b0);
      fill(len, 1'b0, '0, 1'b0);
      do_write(IW'($urandom), addr, len, $urandom_range(0, 2), ($urandom_range(0, 5) == 0), 1'b0);
      do_read(IW'($urandom), addr, len, $urandom_range(0, len), $urandom_range(0, 3), 1'b0);
    end
  endtask

  task automatic test_reset_midburst();
    int t;
    fill(15, 1'b1, '0, 1'b0);
    do_write(18'h7, 32'h2000, 15, 0, 1'b0, 1'b0);
    ARID = 18'h9; ARADDR = 32'h2000; ARLEN = 8'd15; ARVALID = 1'b1;
    t = 0;
    while (ARREADY !== 1'b1 && t < 64) begin @(posedge ACLK); #1; t++; end
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      t = 0;
      while (RVALID !== 1'b1 && t < 64) begin @(posedge ACLK); #1; t++; end
      RREADY = 1'b1;
      @(posedge ACLK); #1;
      RREADY = 1'b0;
    end
    t = 0;
    while (RVALID !== 1'b1 && t < 64) begin @(posedge ACLK); #1; t++; end
    n_checks++;
    if (RVALID !== 1'b1 || RDATA !== ref_mem[259])
      begin n_fail++; $display("FAIL beat3_before_reset: RVALID=%b RDATA=%h required 1/%h", RVALID, RDATA, ref_mem[259]); end
    ARESETn = 1'b0;
    #1;
    check_all_zero("midburst_reset_outputs");
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    n_checks++;
    if (ARREADY !== 1'b1 || AWREADY !== 1'b1 || RVALID !== 1'b0)
      begin n_fail++; $display("FAIL ready_after_midburst_reset: ARREADY=%b AWREADY=%b RVALID=%b required 1/1/0", ARREADY, AWREADY, RVALID); end
    do_read(18'hA, 32'h2000, 15, -1, 0, 1'b1);
  endtask

  initial begin
    AWID = '0; AWADDR = '0; AWLEN = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARVALID = 1'b0; RREADY = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_strobe();
    test_out_of_range();
    test_backpressure();
    test_concurrent();
    test_random();
    test_reset_midburst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
